// File: rtl/uart_tx_controller_pkg.sv
// uart_tx_controller_pkg: shared UART constants, serializer state encodings and parity helper
package uart_tx_controller_pkg;
  localparam int UART_BAUD_DIV_50M    = 5209;
  localparam int UART_FRAME_DATA_BITS = 8;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  function automatic logic frame_parity(input logic [7:0] b, input logic inv);
    return ^b ^ inv;
  endfunction
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: one byte per frame -- start, 8 data LSB-first, even parity, STOP_BITS stops
module uart_tx_serializer
  import uart_tx_controller_pkg::*;
#(
  parameter int BAUD_DIV  = UART_BAUD_DIV_50M,
  parameter int STOP_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  input  logic       i_bad_parity,
  output logic       o_ready,
  output logic       o_finish,
  output logic       o_idle,
  output logic       o_tx
);
  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  logic [2:0]    r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          w_tick;
  assign w_tick   = r_baud == BW'(BAUD_DIV - 1);
  assign o_idle   = r_state == S_IDLE;
  // ready in the final cycle of the last stop bit lets the next frame start with no idle gap
  assign o_finish = (r_state == S_STOP) && (r_bit == 3'(STOP_BITS - 1)) && w_tick;
  assign o_ready  = o_idle | o_finish;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      o_tx    <= 1'b1;
    end else if (i_load && o_ready) begin
      r_state <= S_START;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= i_byte;
      r_par   <= frame_parity(i_byte, i_bad_parity);
      o_tx    <= 1'b0;
    end else if (!o_idle) begin
      r_baud <= w_tick ? '0 : r_baud + 1'b1;
      if (w_tick)
        case (r_state)
          S_START: begin
            r_state <= S_DATA;
            o_tx    <= r_shift[0];
          end
          S_DATA:
            if (r_bit == 3'(UART_FRAME_DATA_BITS - 1)) begin
              r_state <= S_PARITY;
              r_bit   <= '0;
              o_tx    <= r_par;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b1, r_shift[7:1]};
              o_tx    <= r_shift[1];
            end
          S_PARITY: begin
            r_state <= S_STOP;
            o_tx    <= 1'b1;
          end
          default:
            if (o_finish) begin
              r_state <= S_IDLE;
              r_bit   <= '0;
            end else r_bit <= r_bit + 3'd1;
        endcase
    end
endmodule

// File: rtl/uart_tx_controller.sv
// uart_tx_controller: word FIFO plus holding register feeding the byte serializer MSB-byte first
module uart_tx_controller
  import uart_tx_controller_pkg::*;
#(
  parameter int BAUD_DIV  = UART_BAUD_DIV_50M,
  parameter int STOP_BITS = 2,
  parameter int FIFO_AW   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               word_valid,
  input  logic [31:0]        word_data,
  output logic               word_ready,
  input  logic               bad_parity,
  output logic               tx,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count
);
  logic [31:0]    r_mem [2**FIFO_AW];
  logic [FIFO_AW:0] r_wp, r_rp;
  logic [31:0]    r_hold;
  logic [1:0]     r_idx;
  logic           r_have;
  logic           w_push, w_pop, w_chain, w_empty, w_load;
  logic           w_ready, w_finish, w_idle;
  logic [31:0]    w_head;
  logic [7:0]     w_byte;
  assign fifo_count = r_wp - r_rp;
  assign word_ready = !((r_wp[FIFO_AW] != r_rp[FIFO_AW]) && (r_wp[FIFO_AW-1:0] == r_rp[FIFO_AW-1:0]));
  assign w_empty    = r_wp == r_rp;
  assign w_push     = word_valid & word_ready;
  assign w_head     = r_mem[r_rp[FIFO_AW-1:0]];
  assign w_pop      = !r_have & !w_empty & w_ready;
  // a word waiting at the end of the last frame goes straight to the serializer, keeping words gapless
  assign w_chain    = w_pop & w_finish;
  assign w_load     = (w_ready & r_have) | w_chain;
  assign w_byte     = w_chain ? w_head[31:24] : r_hold[{~r_idx, 3'b000} +: 8];
  assign busy       = !w_idle | !w_empty | r_have;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp[FIFO_AW-1:0]] <= word_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_hold <= '0;
      r_idx  <= '0;
      r_have <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_chain) begin
        r_hold <= w_head;
        r_idx  <= 2'd1;
        r_have <= 1'b1;
      end else if (w_pop) begin
        r_hold <= w_head;
        r_idx  <= 2'd0;
        r_have <= 1'b1;
      end else if (w_load) begin
        r_idx  <= r_idx + 2'd1;
        r_have <= r_idx != 2'd3;
      end
    end
  uart_tx_serializer #(
    .BAUD_DIV (BAUD_DIV),
    .STOP_BITS(STOP_BITS)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_byte      (w_byte),
    .i_bad_parity(bad_parity),
    .o_ready     (w_ready),
    .o_finish    (w_finish),
    .o_idle      (w_idle),
    .o_tx        (tx)
  );
endmodule

// File: tb/tb_uart_tx_controller.sv
// tb_uart_tx_controller: decodes the tx line into frames and compares against a word-level model
module tb_uart_tx_controller;
  localparam int BD = 4, SB = 2, AW = 2, FL = (10 + SB) * BD;
  logic          clk = 1'b0, rst = 1'b1, word_valid = 1'b0, bad_parity = 1'b0;
  logic [31:0]   word_data = '0;
  logic          word_ready, tx, busy;
  logic [AW:0]   fifo_count;
  int            cyc = 0, total = 0, bad = 0, peak = 0;
  logic [7:0]    mb[$], eb[$];
  logic          mp[$], mok[$], ep[$];
  int            mt[$];

  uart_tx_controller #(.BAUD_DIV(BD), .STOP_BITS(SB), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready), .bad_parity(bad_parity), .tx(tx), .busy(busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst && int'(fifo_count) > peak) peak = int'(fifo_count);

  // line decoder: samples each bit mid-period; frames overlapped by reset are discarded
  initial begin : mon
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin : frame
        int t0;
        logic [7:0] b;
        logic p, ok, ab;
        t0 = cyc; ab = rst; ok = 1'b1;
        repeat (2) @(negedge clk);
        ok = ok & (tx === 1'b0); ab = ab | rst;
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = tx; ab = ab | rst;
        end
        repeat (BD) @(negedge clk);
        p = tx; ab = ab | rst;
        for (int i = 0; i < SB; i++) begin
          repeat (BD) @(negedge clk);
          ok = ok & (tx === 1'b1); ab = ab | rst;
        end
        if (!ab) begin
          mb.push_back(b); mp.push_back(p); mok.push_back(ok); mt.push_back(t0);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_word(input logic [31:0] w, input int badidx);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] by;
      by = 8'(w >> (24 - 8 * k));
      eb.push_back(by);
      ep.push_back((^by) ^ (k == badidx));
    end
  endtask

  task automatic push(input logic [31:0] w, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    word_valid = 1'b1; word_data = w;
    while (!word_ready && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    acc = cyc; word_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int k;
    k = 0;
    while (mb.size() < n && k < 5000) begin @(negedge clk); k++; end
    chk("frames_timeout", mb.size() >= n, 1);
  endtask

  task automatic wait_idle(output int c);
    int k;
    k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < 5000) begin @(negedge clk); k++; end
    chk("idle_timeout", k < 5000, 1);
    c = cyc;
  endtask

  task automatic check_stream(input string tag, input bit spacing);
    chk({tag, "_nframes"}, mb.size(), eb.size());
    for (int i = 0; i < eb.size() && i < mb.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), mb[i], eb[i]);
      chk($sformatf("%s_par%0d", tag, i), mp[i], ep[i]);
      chk($sformatf("%s_framing%0d", tag, i), mok[i], 1);
      if (spacing && i > 0) chk($sformatf("%s_gap%0d", tag, i), mt[i] - mt[i-1], FL);
    end
    mb.delete(); mp.delete(); mok.delete(); mt.delete(); eb.delete(); ep.delete();
  endtask

  initial begin
    int acc, a2, c, t0;
    logic [31:0] w;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_tx", tx, 1);
    chk("idle_busy", busy, 0);
    chk("idle_ready", word_ready, 1);
    chk("idle_count", fifo_count, 0);

    push(32'h12345678, acc);
    add_word(32'h12345678, -1);
    wait_frames(1);
    chk("start_latency", mt[0] - acc, 2);
    t0 = mt[0];
    wait_idle(c);
    chk("busy_fall", c - t0, 4 * FL);
    wait_frames(4);
    check_stream("single", 1);

    w = $urandom;
    push(w, acc);
    add_word(w, -1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      push(w, a2);
      add_word(w, -1);
    end
    @(negedge clk);
    chk("full_count", fifo_count, 4);
    chk("full_ready", word_ready, 0);
    w = $urandom;
    push(w, a2);
    add_word(w, -1);
    chk("fifth_accept", a2 - acc, 2 + 4 * FL + 1);
    chk("count_after_fifth", fifo_count, 4);
    wait_frames(24);
    wait_idle(c);
    check_stream("burst", 1);
    chk("peak_count", peak, 4);

    push(32'hA5A5A5A5, acc);
    add_word(32'hA5A5A5A5, 1);
    while (cyc < acc + 2) @(negedge clk);
    bad_parity = 1'b1;
    while (cyc < acc + 2 + FL) @(negedge clk);
    bad_parity = 1'b0;
    wait_frames(4);
    wait_idle(c);
    check_stream("badpar", 1);

    push(32'hCAFEF00D, acc);
    push(32'h11111111, a2);
    while (cyc < acc + 7) @(negedge clk);
    chk("pre_rst_tx", tx, 0);
    chk("pre_rst_count", fifo_count, 1);
    rst = 1'b1;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", word_ready, 1);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    mb.delete(); mp.delete(); mok.delete(); mt.delete(); eb.delete(); ep.delete();
    push(32'h9ABCDEF0, acc);
    add_word(32'h9ABCDEF0, -1);
    wait_frames(4);
    wait_idle(c);
    check_stream("post_rst", 1);

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 60)) @(negedge clk);
      w = $urandom;
      push(w, acc);
      add_word(w, -1);
    end
    wait_frames(24);
    wait_idle(c);
    check_stream("random", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
